// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: ALU mode encodings,
// instruction field positions, FSM state encodings and an instruction decoder.
package alu_issue_unit_pkg;

    // The unit passes this field to the ALU unchanged.
    typedef enum logic [2:0] {
        MODE_ADD    = 3'd0,
        MODE_SUBST  = 3'd1,
        MODE_SHIFTR = 3'd2,
        MODE_SHIFTL = 3'd3,
        MODE_AND    = 3'd4,
        MODE_OR     = 3'd5,
        MODE_NOT    = 3'd6,
        MODE_XOR    = 3'd7
    } alu_mode_e;

    // Instruction layout: [15:13] mode, [12:10] rd, [9:7] rs1, [6:4] rs2.
    // Bits [3:0] are reserved and ignored.
    localparam int INSTR_W = 16;
    localparam int MODE_HI = 15;
    localparam int MODE_LO = 13;
    localparam int RD_HI   = 12;
    localparam int RD_LO   = 10;
    localparam int RS1_HI  = 9;
    localparam int RS1_LO  = 7;
    localparam int RS2_HI  = 6;
    localparam int RS2_LO  = 4;

    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPS  = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    typedef struct packed {
        alu_mode_e             mode;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } dec_instr_t;

    function automatic dec_instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        dec_instr_t d;
        d.mode = alu_mode_e'(raw[MODE_HI:MODE_LO]);
        d.rd   = raw[RD_HI:RD_LO];
        d.rs1  = raw[RS1_HI:RS1_LO];
        d.rs2  = raw[RS2_HI:RS2_LO];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Upstream-facing bus of the ALU issue unit.
//   instr_valid / instr_ready / instr : instruction handshake
//   ld_valid / ld_addr / ld_data      : direct register load request
// master = upstream (instruction source), slave = the issue unit.
interface alu_issue_unit_if;
    import alu_issue_unit_pkg::*;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_W-1:0]    instr;
    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_addr;
    logic [15:0]           ld_data;

    modport master (
        output instr_valid,
        output instr,
        output ld_valid,
        output ld_addr,
        output ld_data,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        output instr_ready
    );
endinterface

// File: rtl/alu_reg_file.sv
// 8 x DATA_W register file for the ALU issue unit.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata      : synchronous write port
//   raddr1/rdata1,
//   raddr2/rdata2         : combinational operand read ports
//   dbg_addr/dbg_data     : combinational debug read port
// R0 is never written, so it reads zero forever after reset.
module alu_reg_file
    import alu_issue_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata2,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [DATA_W-1:0]   rf_reg [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;

    // Per-entry write decode; entry 0 never matches, which hardwires R0 to zero.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_hit
            assign wr_hit[gi] = we && (waddr == REG_ADDR_W'(gi)) && (gi != 0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    rf_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata1   = rf_reg[raddr1];
    assign rdata2   = rf_reg[raddr2];
    assign dbg_data = rf_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue / writeback stage wrapped around a fixed-latency 16-bit ALU.
// Accepts one instruction at a time, reads rs1/rs2 from the register file,
// drives the ALU operands, waits ALU_LAT cycles, then writes the ALU result
// back to rd and pulses done with the result and a zero flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   up                  : instruction handshake + direct register load (slave)
//   alu_in1/in2/mode    : registered operands/operation to the ALU
//   alu_result          : ALU output, sampled on the last EXEC edge
//   busy, done          : instruction in flight / one-cycle completion pulse
//   result, zero        : last written-back value and its zero flag
//   dbg_addr, dbg_data  : combinational register file debug read
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_issue_unit_if.slave       up,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    output logic [2:0]            alu_mode,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  zero,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e                state_reg, state_next;
    dec_instr_t            instr_reg;
    logic [CNT_W-1:0]      lat_cnt_reg;
    logic [DATA_W-1:0]     alu_in1_reg, alu_in2_reg;
    alu_mode_e             alu_mode_reg;
    logic                  done_reg;
    logic [DATA_W-1:0]     result_reg;
    logic                  zero_reg;

    logic                  accept;
    logic                  exec_last;
    logic                  wb_fire;
    logic                  ld_fire;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [DATA_W-1:0]     rs1_data, rs2_data;

    // Reserved instruction bits are deliberately ignored.
    logic unused_instr_bits;
    assign unused_instr_bits = ^up.instr[3:0];

    // A pending load has priority over an instruction in IDLE, so the
    // instruction is simply not taken that cycle.
    assign up.instr_ready = (state_reg == ST_IDLE) && !up.ld_valid && !rst;
    assign accept         = up.instr_valid && up.instr_ready;
    assign exec_last      = (lat_cnt_reg == CNT_W'(ALU_LAT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_OPS;
            ST_OPS:                 state_next = ST_EXEC;
            ST_EXEC: if (exec_last) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: load and writeback share the single register file write
    // port; they can never coincide because loads only happen in IDLE.
    always_comb begin
        wb_fire  = (state_reg == ST_EXEC) && exec_last;
        ld_fire  = (state_reg == ST_IDLE) && up.ld_valid;
        rf_we    = wb_fire || ld_fire;
        rf_waddr = wb_fire ? instr_reg.rd : up.ld_addr;
        rf_wdata = wb_fire ? alu_result : up.ld_data;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg    <= '0;
            lat_cnt_reg  <= '0;
            alu_in1_reg  <= '0;
            alu_in2_reg  <= '0;
            alu_mode_reg <= MODE_ADD;
            done_reg     <= 1'b0;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
        end else begin
            if (accept) begin
                instr_reg <= decode_instr(up.instr);
            end
            if (state_reg == ST_OPS) begin
                alu_in1_reg  <= rs1_data;
                alu_in2_reg  <= rs2_data;
                alu_mode_reg <= instr_reg.mode;
                lat_cnt_reg  <= '0;
            end else if ((state_reg == ST_EXEC) && !exec_last) begin
                lat_cnt_reg <= lat_cnt_reg + 1'b1;
            end
            done_reg <= wb_fire;
            if (wb_fire) begin
                result_reg <= alu_result;
                zero_reg   <= (alu_result == '0);
            end
        end
    end

    alu_reg_file #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (instr_reg.rs1),
        .rdata1   (rs1_data),
        .raddr2   (instr_reg.rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_in1  = alu_in1_reg;
    assign alu_in2  = alu_in2_reg;
    assign alu_mode = alu_mode_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign result   = result_reg;
    assign zero     = zero_reg;

endmodule
